// File: rtl/ins_cache_assoc_pkg.sv
// Shared types and address-field helpers for the set-associative instruction-cache controller.
// Also holds the node numbering used by the pseudo-LRU tree.
package ins_cache_assoc_pkg;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        FETCH = 2'd1,
        INVAL = 2'd2,
        FLUSH = 2'd3
    } cache_cmd_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT
    } cache_state_t;

    function automatic int off_width(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets, input int line_bytes);
        return addr_w - idx_width(sets) - off_width(line_bytes);
    endfunction

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int plru_width(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

    // Tree nodes are heap-numbered: node n sits at depth node_level(n), position node_pos(n).
    function automatic int node_level(input int n);
        return $clog2(n + 2) - 1;
    endfunction

    function automatic int node_pos(input int n);
        return n + 1 - (1 << node_level(n));
    endfunction

endpackage

// File: rtl/ins_cache_assoc_plru.sv
// Combinational tree pseudo-LRU: updates the node bits for a used way and names the victim way.
// A node bit of 1 steers the victim search into the right subtree.
module plru_tree
    import ins_cache_assoc_pkg::*;
#(
    parameter  int WAYS   = 4,
    localparam int PLRU_W = plru_width(WAYS),
    localparam int WAY_W  = way_width(WAYS)
) (
    input  logic [PLRU_W-1:0] bits_in,
    input  logic [WAY_W-1:0]  touch_way,
    output logic [PLRU_W-1:0] bits_out,
    output logic [WAY_W-1:0]  victim_way
);

    localparam int LEVELS = $clog2(WAYS);

    logic [WAY_W-1:0] dir_bits;
    logic             dir;

    // NOTE: every variable of a combinational block gets a value before any branch, so no latch is inferred.
    always_comb begin
        bits_out = bits_in;
        dir_bits = '0;
        for (int n = 0; n < WAYS - 1; n++) begin
            if ((touch_way >> (LEVELS - node_level(n))) == WAY_W'(node_pos(n))) begin
                dir_bits    = touch_way >> (LEVELS - 1 - node_level(n));
                bits_out[n] = ~dir_bits[0];
            end
        end
    end

    // The victim bits already chosen form the position prefix of the node to read at the next depth.
    always_comb begin
        victim_way = '0;
        dir        = 1'b0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            dir = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) begin
                if (node_level(n) == lvl && victim_way == WAY_W'(node_pos(n)))
                    dir = bits_in[n];
            end
            victim_way = (victim_way << 1) | WAY_W'(dir);
        end
    end

endmodule

// File: rtl/ins_cache_assoc.sv
// N-way set-associative instruction-cache tag/state controller with tree pseudo-LRU replacement.
// Blocking: one FETCH/INVAL/FLUSH in flight, misses fetch a line from the next level.
module ins_cache_assoc
    import ins_cache_assoc_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 16384,
    parameter int WAYS       = 4,
    parameter int LINE_BYTES = 64,
    parameter int CNT_W      = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [1:0]                         req_cmd,
    input  logic [ADDR_W-1:0]                  req_addr,
    output logic                               resp_valid,
    output logic                               resp_hit,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_W-$clog2(LINE_BYTES)-1:0] mem_req_addr,
    input  logic                               mem_fill_done,
    output logic [CNT_W-1:0]                   hit_cnt,
    output logic [CNT_W-1:0]                   miss_cnt,
    output logic [CNT_W-1:0]                   read_cnt,
    output logic [CNT_W-1:0]                   inv_cnt
);

    localparam int OFF_W  = off_width(LINE_BYTES);
    localparam int IDX_W  = idx_width(SETS);
    localparam int TAG_W  = tag_width(ADDR_W, SETS, LINE_BYTES);
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int WAY_W  = way_width(WAYS);
    localparam int PLRU_W = plru_width(WAYS);

    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]   valid_mem [SETS];
    logic [PLRU_W-1:0] plru_mem  [SETS];

    cache_state_t      state_q, state_d;
    cache_cmd_t        cmd_q, req_cmd_e;
    logic [LINE_W-1:0] line_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [WAY_W-1:0]  victim_q;
    logic [CNT_W-1:0]  hit_q, miss_q, read_q, inv_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WAYS-1:0]   set_valid, hit_vec;
    logic              hit_any, free_any, accept;
    logic [WAY_W-1:0]  hit_way, free_way, touch_way, plru_victim;
    logic [PLRU_W-1:0] plru_next;
    logic              init_we, touch_we, inval_we, fill_we;
    logic              unused_offset;

    assign req_cmd_e     = cache_cmd_t'(req_cmd);
    assign accept        = req_valid && (state_q == IDLE);
    assign idx           = line_q[IDX_W-1:0];
    assign tag           = line_q[LINE_W-1:IDX_W];
    assign set_valid     = valid_mem[idx];
    assign unused_offset = ^req_addr[OFF_W-1:0];

    // Descending scan so the lowest-index matching or empty way wins.
    always_comb begin
        hit_vec  = '0;
        hit_way  = '0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = set_valid[w] && (tag_mem[idx][w] == tag);
            if (hit_vec[w])    hit_way  = WAY_W'(w);
            if (!set_valid[w]) free_way = WAY_W'(w);
        end
    end

    assign hit_any   = |hit_vec;
    assign free_any  = ~&set_valid;
    assign touch_way = (state_q == MISS_WAIT) ? victim_q : hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_in    (plru_mem[idx]),
        .touch_way  (touch_way),
        .bits_out   (plru_next),
        .victim_way (plru_victim)
    );

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:      if (ptr_q == IDX_W'(SETS - 1)) state_d = IDLE;
            IDLE: begin
                if (req_valid) begin
                    case (req_cmd_e)
                        FETCH, INVAL: state_d = LOOKUP;
                        FLUSH:        state_d = INIT;
                        default:      state_d = IDLE;
                    endcase
                end
            end
            LOOKUP:    state_d = (cmd_q == FETCH && !hit_any) ? MISS_REQ : IDLE;
            MISS_REQ:  if (mem_req_ready) state_d = MISS_WAIT;
            MISS_WAIT: if (mem_fill_done) state_d = IDLE;
            default:   state_d = INIT;
        endcase
    end

    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        mem_req_valid = 1'b0;
        init_we       = 1'b0;
        touch_we      = 1'b0;
        inval_we      = 1'b0;
        fill_we       = 1'b0;
        case (state_q)
            INIT: init_we = 1'b1;
            IDLE: req_ready = 1'b1;
            LOOKUP: begin
                if (cmd_q == INVAL) begin
                    resp_valid = 1'b1;
                    resp_hit   = hit_any;
                    inval_we   = hit_any;
                end else if (hit_any) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'b1;
                    touch_we   = 1'b1;
                end
            end
            MISS_REQ: mem_req_valid = 1'b1;
            MISS_WAIT: begin
                if (mem_fill_done) begin
                    resp_valid = 1'b1;
                    fill_we    = 1'b1;
                    touch_we   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            cmd_q    <= NOP;
            line_q   <= '0;
            victim_q <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            read_q   <= '0;
            inv_q    <= '0;
        end else begin
            if (state_q == INIT) ptr_q <= ptr_q + IDX_W'(1);
            if (accept) begin
                cmd_q  <= req_cmd_e;
                line_q <= req_addr[ADDR_W-1:OFF_W];
                if (req_cmd_e == FETCH) read_q <= read_q + CNT_W'(1);
                if (req_cmd_e == FLUSH) ptr_q  <= '0;
            end
            if (state_q == LOOKUP && cmd_q == FETCH) begin
                if (hit_any) begin
                    hit_q <= hit_q + CNT_W'(1);
                end else begin
                    miss_q   <= miss_q + CNT_W'(1);
                    victim_q <= free_any ? free_way : plru_victim;
                end
            end
            if (inval_we) inv_q <= inv_q + CNT_W'(1);
        end
    end

    // NOTE: the arrays have no reset; valid and PLRU bits are cleared by the INIT sweep, tags need no clearing.
    always_ff @(posedge clk) begin
        if (init_we) begin
            valid_mem[ptr_q] <= '0;
            plru_mem[ptr_q]  <= '0;
        end
        if (inval_we) valid_mem[idx][hit_way] <= 1'b0;
        if (fill_we) begin
            tag_mem[idx][victim_q]   <= tag;
            valid_mem[idx][victim_q] <= 1'b1;
        end
        if (touch_we) plru_mem[idx] <= plru_next;
    end

    assign mem_req_addr = line_q;
    assign hit_cnt      = hit_q;
    assign miss_cnt     = miss_q;
    assign read_cnt     = read_q;
    assign inv_cnt      = inv_q;

endmodule
